tick_event_counter: RTL and testbench
=====================================

TICK_EVENT_COUNTER -- requirements
Module: tick_event_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the width of the limit and the event count.
REQ-002 Port clk SHALL be an input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 Port rst SHALL be an input, 1 bit, asynchronous active-high reset.
REQ-004 Port tick SHALL be an input, 1 bit, the terminal-count level from the upstream load counter; it may stay high for many cycles.
REQ-005 Port arm SHALL be an input, 1 bit, a request to start an event-counting run.
REQ-006 Port clr SHALL be an input, 1 bit, a request to abort the run or clear completion status.
REQ-007 Port limit_load SHALL be an input, 1 bit, a strobe that writes limit_data into the limit register.
REQ-008 Port limit_data SHALL be an input, WIDTH bits, the requested number of events per run.
REQ-009 Port irq SHALL be an output, 1 bit, a one-cycle completion pulse.
REQ-010 Port done SHALL be an output, 1 bit, a sticky completion flag.
REQ-011 Port busy SHALL be an output, 1 bit, high while a run is in progress.
REQ-012 Port ovf SHALL be an output, 1 bit, a sticky flag for tick edges seen after completion.
REQ-013 Port event_cnt SHALL be an output, WIDTH bits, the number of events counted in the current run.

Function
REQ-014 Event detection SHALL use a registered edge: tick_q <= tick every cycle; event = tick & ~tick_q; a held-high tick SHALL count once.
REQ-015 The FSM SHALL have exactly three states, IDLE, ARMED and DONE, with busy=1 only in ARMED and done=1 only in DONE.
REQ-016 The limit register SHALL load limit_data on a cycle with limit_load=1 only in IDLE; limit_load SHALL be ignored in ARMED and DONE.
REQ-017 An effective limit of 0 SHALL be treated as 1.
REQ-018 In IDLE, arm=1 SHALL enter ARMED with event_cnt=0; an event in that same cycle SHALL NOT be counted.
REQ-019 In ARMED, each event SHALL increment event_cnt by 1 (WIDTH-bit arithmetic).
REQ-020 In ARMED, when event_cnt+1 equals the effective limit, the FSM SHALL enter DONE and irq SHALL be 1 for exactly the following cycle.
REQ-021 Latency from the clock edge that samples the final tick rise to irq high SHALL be 1 cycle (irq is registered); event_cnt SHALL then equal the limit and hold.
REQ-022 In ARMED, clr=1 SHALL return to IDLE with event_cnt=0 and no irq; clr SHALL have priority over a same-cycle event.
REQ-023 In ARMED, arm=1 SHALL be ignored; there is no restart without clr.
REQ-024 In DONE, an event SHALL set ovf=1; event_cnt SHALL NOT change.
REQ-025 In DONE, clr=1 with arm=0 SHALL go to IDLE and clear done, ovf and event_cnt.
REQ-026 In DONE, clr=1 with arm=1 SHALL go directly to ARMED with event_cnt=0 and done=ovf=0.
REQ-027 In DONE, arm=1 alone SHALL be ignored.
REQ-028 In IDLE, events SHALL be ignored and SHALL NOT set ovf.
REQ-029 With limit_load=1 and arm=1 in the same IDLE cycle, the new limit SHALL apply to the run started.

Reset
REQ-030 While rst=1, asynchronously and regardless of clk, the block SHALL set state=IDLE, tick_q=0, event_cnt=0, irq=0, done=0, busy=0 and ovf=0.
REQ-031 While rst=1, the limit register SHALL be set to all ones (16'hFFFF at default WIDTH).
REQ-032 Reset asserted mid-run SHALL discard the run with no irq.
REQ-033 After rst deasserts, operation SHALL resume on the next rising clk edge, with an already-high tick counting as one edge.

Verification
REQ-034 Load 3 in IDLE, arm, then 3 separate tick pulses -> event_cnt steps 1,2,3; irq high exactly one cycle after the third rise; done=1, busy=0.
REQ-035 Limit 2, armed, tick held high 10 cycles then low then high -> counts 1 then 2; irq once; ovf=0.
REQ-036 Limit 4, armed, 2 events, clr with a tick rise in the same cycle -> IDLE, event_cnt=0, no irq; a subsequent limit_load of 5 is accepted.
REQ-037 Limit 1 reached, then 1 more tick rise -> ovf=1, event_cnt stays 1; clr+arm together -> ARMED, event_cnt=0, done=ovf=0.
REQ-038 Limit 0 loaded, armed, 1 tick rise -> completes as limit 1; limit_load of 7 during ARMED -> limit unchanged (next run still completes after 1 event).
REQ-039 rst pulsed during ARMED at event_cnt=2 -> all outputs 0 immediately, limit=16'hFFFF, no irq after release.

Source files
------------

// File: rtl/tick_event_counter.sv
// Counts rising edges of a terminal-count level over a programmable-length run,
// flagging completion (sticky done, one-cycle irq) and edges seen after completion (ovf).
module tick_event_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             arm,
    input  logic             clr,
    input  logic             limit_load,
    input  logic [WIDTH-1:0] limit_data,
    output logic             irq,
    output logic             done,
    output logic             busy,
    output logic             ovf,
    output logic [WIDTH-1:0] event_cnt
);

    typedef enum logic [1:0] {StIdle, StArmed, StDone} state_e;

    state_e           state_q, state_d;
    logic             tick_q;
    logic             evt;
    logic             complete;
    logic             limit_we;
    logic             irq_q, irq_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] limit_q;
    logic [WIDTH-1:0] limit_eff;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] cnt_inc;

    assign evt       = tick & ~tick_q;
    assign cnt_inc   = cnt_q + WIDTH'(1);
    // A programmed limit of zero behaves as a single-event run.
    assign limit_eff = (limit_q == '0) ? WIDTH'(1) : limit_q;
    assign complete  = evt && (cnt_inc == limit_eff);
    assign limit_we  = (state_q == StIdle) && limit_load;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (arm) begin
                    state_d = StArmed;
                end
            end
            StArmed: begin
                if (clr) begin
                    state_d = StIdle;
                end else if (complete) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (clr) begin
                    state_d = arm ? StArmed : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Datapath next-state; clr always wins over a same-cycle edge.
    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        irq_d = 1'b0;
        case (state_q)
            StIdle: begin
                cnt_d = '0;
            end
            StArmed: begin
                if (clr) begin
                    cnt_d = '0;
                end else if (evt) begin
                    cnt_d = cnt_inc;
                    irq_d = complete;
                end
            end
            StDone: begin
                if (clr) begin
                    cnt_d = '0;
                    ovf_d = 1'b0;
                end else if (evt) begin
                    ovf_d = 1'b1;
                end
            end
            default: begin
                cnt_d = '0;
                ovf_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_q  <= 1'b0;
            cnt_q   <= '0;
            irq_q   <= 1'b0;
            ovf_q   <= 1'b0;
            limit_q <= '1;
        end else begin
            tick_q <= tick;
            cnt_q  <= cnt_d;
            irq_q  <= irq_d;
            ovf_q  <= ovf_d;
            if (limit_we) begin
                limit_q <= limit_data;
            end
        end
    end

    // Outputs
    always_comb begin
        busy      = (state_q == StArmed);
        done      = (state_q == StDone);
        irq       = irq_q;
        ovf       = ovf_q;
        event_cnt = cnt_q;
    end

endmodule

// File: tb/tb_tick_event_counter.sv
// Self-checking bench for tick_event_counter: directed vector table, async reset
// sequence, then randomized traffic against a behavioural model.
module tb_tick_event_counter;

    localparam int unsigned WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             tick = 1'b0;
    logic             arm = 1'b0;
    logic             clr = 1'b0;
    logic             limit_load = 1'b0;
    logic [WIDTH-1:0] limit_data = '0;
    logic             irq, done, busy, ovf;
    logic [WIDTH-1:0] event_cnt;

    int checks   = 0;
    int failures = 0;

    tick_event_counter #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .arm        (arm),
        .clr        (clr),
        .limit_load (limit_load),
        .limit_data (limit_data),
        .irq        (irq),
        .done       (done),
        .busy       (busy),
        .ovf        (ovf),
        .event_cnt  (event_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             tick;
        logic             arm;
        logic             clr;
        logic             ld;
        logic [WIDTH-1:0] data;
        logic             e_irq;
        logic             e_done;
        logic             e_busy;
        logic             e_ovf;
        logic [WIDTH-1:0] e_cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic t, input logic a, input logic c, input logic l,
                                input int d, input logic ei, input logic ed, input logic eb,
                                input logic eo, input int ec);
        vec_t v;
        v.tick = t; v.arm = a; v.clr = c; v.ld = l; v.data = WIDTH'(d);
        v.e_irq = ei; v.e_done = ed; v.e_busy = eb; v.e_ovf = eo; v.e_cnt = WIDTH'(ec);
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [WIDTH+3:0] exp);
        logic [WIDTH+3:0] act;
        act = {irq, done, busy, ovf, event_cnt};
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got irq/done/busy/ovf/cnt=%b/%b/%b/%b/%0d want %b/%b/%b/%b/%0d",
                     name, act[WIDTH+3], act[WIDTH+2], act[WIDTH+1], act[WIDTH],
                     act[WIDTH-1:0], exp[WIDTH+3], exp[WIDTH+2], exp[WIDTH+1], exp[WIDTH],
                     exp[WIDTH-1:0]);
        end
    endtask

    task automatic drive(input logic t, input logic a, input logic c, input logic l,
                         input int d);
        tick = t; arm = a; clr = c; limit_load = l; limit_data = WIDTH'(d);
        @(posedge clk);
        #1;
    endtask

    // Behavioural model: mode 0 idle, 1 counting, 2 finished.
    int               m_mode;
    int               m_cnt;
    int               m_lim;
    bit               m_ovf, m_irq, m_prev;

    function automatic void model_reset();
        m_mode = 0; m_cnt = 0; m_lim = 65535; m_ovf = 0; m_irq = 0; m_prev = 0;
    endfunction

    function automatic void model_step(input bit t, input bit a, input bit c, input bit l,
                                       input int d);
        bit rise;
        int target;
        rise   = t && !m_prev;
        m_prev = t;
        m_irq  = 0;
        target = (m_lim == 0) ? 1 : m_lim;
        if (m_mode == 0) begin
            if (l) m_lim = d;
            if (a) begin m_mode = 1; m_cnt = 0; end
        end else if (m_mode == 1) begin
            if (c) begin
                m_mode = 0; m_cnt = 0;
            end else if (rise) begin
                m_cnt = (m_cnt + 1) % 65536;
                if (m_cnt == target) begin m_mode = 2; m_irq = 1; end
            end
        end else begin
            if (c) begin
                m_ovf = 0; m_cnt = 0; m_mode = a ? 1 : 0;
            end else if (rise) begin
                m_ovf = 1;
            end
        end
    endfunction

    initial begin
        // Three separate pulses against limit 3
        add(0,0,0,1,3, 0,0,0,0,0);
        add(0,1,0,0,0, 0,0,1,0,0);
        add(1,0,0,0,0, 0,0,1,0,1);
        add(0,0,0,0,0, 0,0,1,0,1);
        add(1,1,0,0,0, 0,0,1,0,2);   // arm while counting is ignored
        add(0,0,0,0,0, 0,0,1,0,2);
        add(1,0,0,0,0, 1,1,0,0,3);
        add(0,0,0,0,0, 0,1,0,0,3);
        add(0,1,0,0,0, 0,1,0,0,3);   // arm alone in done is ignored
        add(0,0,1,0,0, 0,0,0,0,0);
        add(1,0,0,0,0, 0,0,0,0,0);   // idle edge: no ovf
        add(0,0,0,0,0, 0,0,0,0,0);
        // Held-high tick counts once, limit 2
        add(0,0,0,1,2, 0,0,0,0,0);
        add(0,1,0,0,0, 0,0,1,0,0);
        add(1,0,0,0,0, 0,0,1,0,1);
        for (int i = 0; i < 9; i++) add(1,0,0,0,0, 0,0,1,0,1);
        add(0,0,0,0,0, 0,0,1,0,1);
        add(1,0,0,0,0, 1,1,0,0,2);
        add(1,0,0,0,0, 0,1,0,0,2);
        add(0,0,1,0,0, 0,0,0,0,0);
        // Abort with clr beating a same-cycle edge, then limit 5 accepted
        add(0,0,0,1,4, 0,0,0,0,0);
        add(0,1,0,0,0, 0,0,1,0,0);
        add(1,0,0,0,0, 0,0,1,0,1);
        add(0,0,0,0,0, 0,0,1,0,1);
        add(1,0,0,0,0, 0,0,1,0,2);
        add(0,0,0,0,0, 0,0,1,0,2);
        add(1,0,1,0,0, 0,0,0,0,0);
        add(0,0,0,1,5, 0,0,0,0,0);
        add(0,1,0,0,0, 0,0,1,0,0);
        for (int k = 1; k <= 5; k++) begin
            add(1,0,0,0,0, (k == 5), (k == 5), (k != 5), 0, k);
            add(0,0,0,0,0, 0, (k == 5), (k != 5), 0, k);
        end
        add(0,0,1,0,0, 0,0,0,0,0);
        // Limit 1, overflow, clr+arm restart
        add(0,0,0,1,1, 0,0,0,0,0);
        add(0,1,0,0,0, 0,0,1,0,0);
        add(1,0,0,0,0, 1,1,0,0,1);
        add(0,0,0,0,0, 0,1,0,0,1);
        add(1,0,0,0,0, 0,1,0,1,1);
        add(0,0,0,0,0, 0,1,0,1,1);
        add(0,1,1,0,0, 0,0,1,0,0);
        add(1,0,0,0,0, 1,1,0,0,1);
        add(0,0,1,0,0, 0,0,0,0,0);
        // Limit 0 acts as 1; load during a run is ignored
        add(0,0,0,1,0, 0,0,0,0,0);
        add(0,1,0,0,0, 0,0,1,0,0);
        add(1,0,0,0,0, 1,1,0,0,1);
        add(0,1,1,0,0, 0,0,1,0,0);
        add(0,0,0,1,7, 0,0,1,0,0);
        add(1,0,0,0,0, 1,1,0,0,1);
        add(0,0,1,0,0, 0,0,0,0,0);
        // Load and arm together: new limit applies
        add(0,1,0,1,2, 0,0,1,0,0);
        add(1,0,0,0,0, 0,0,1,0,1);
        add(0,0,0,0,0, 0,0,1,0,1);
        add(1,0,0,0,0, 1,1,0,0,2);
        add(0,0,1,0,0, 0,0,0,0,0);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", '0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].tick, vecs[i].arm, vecs[i].clr, vecs[i].ld, int'(vecs[i].data));
            check($sformatf("vec[%0d]", i),
                  {vecs[i].e_irq, vecs[i].e_done, vecs[i].e_busy, vecs[i].e_ovf, vecs[i].e_cnt});
        end

        // Async reset mid-run discards the run and restores limit to all ones
        drive(0,0,0,1,3);
        drive(0,1,0,0,0);
        drive(1,0,0,0,0);
        drive(0,0,0,0,0);
        drive(1,0,0,0,0);
        check("pre_rst_cnt2", {1'b0, 1'b0, 1'b1, 1'b0, WIDTH'(2)});
        tick = 1'b0;
        #2 rst = 1'b1;
        #1 check("rst_async", '0);
        @(posedge clk);
        #3 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(0,0,0,0,0);
            check("post_rst_quiet", '0);
        end
        drive(0,1,0,0,0);
        for (int k = 1; k <= 5; k++) begin
            drive(1,0,0,0,0);
            drive(0,0,0,0,0);
        end
        check("post_rst_limit_ffff", {1'b0, 1'b0, 1'b1, 1'b0, WIDTH'(5)});
        drive(0,0,1,0,0);

        // Randomized traffic against the model
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 400; i++) begin
            bit t, a, c, l;
            int d;
            t = ($urandom_range(0, 2) != 0) ? ~tick : tick;
            a = ($urandom_range(0, 5) == 0);
            c = ($urandom_range(0, 9) == 0);
            l = ($urandom_range(0, 3) == 0);
            d = $urandom_range(0, 5);
            model_step(t, a, c, l, d);
            drive(t, a, c, l, d);
            check($sformatf("rand[%0d]", i),
                  {m_irq, (m_mode == 2), (m_mode == 1), m_ovf, WIDTH'(m_cnt)});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
